// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained from MEM, issuing a registered redirect.
// Optional statistics counters are built only when BTB_STATS_EN is defined; otherwise the stat ports are tied to 0.
module btb_predictor #(
    parameter int          XLEN     = 32,
    parameter int          IDX_W    = 5,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispredicts
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = XLEN - IDX_W;

    logic [ENTRIES-1:0]      valid_q;
    logic [ENTRIES-1:0][1:0] ctr_q;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [XLEN-1:0]         target_q [ENTRIES];

    logic                    mispredict_q;
    logic [XLEN-1:0]         redirect_q;

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;
    logic             fetch_hit, upd_hit, mis_cond;

    assign fetch_idx = fetch_pc[IDX_W-1:0];
    assign fetch_tag = fetch_pc[XLEN-1:IDX_W];
    assign upd_idx   = upd_pc[IDX_W-1:0];
    assign upd_tag   = upd_pc[XLEN-1:IDX_W];

    // Lookup reads the registered table, so a same-cycle update is seen only on the next cycle.
    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    assign pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(1);

    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mis_cond = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{CTR_INIT}};
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken && ctr_q[upd_idx] != 2'b11)
                    ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
                else if (!upd_taken && ctr_q[upd_idx] != 2'b00)
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= 2'b10;
            end
        end
    end

    // NOTE: tag/target arrays are deliberately left out of reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            mispredict_q <= mis_cond;
            if (mis_cond)
                redirect_q <= upd_taken ? upd_target : upd_pc + XLEN'(1);
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, hits_q, mispredicts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            if (fetch_en)
                lookups_q <= lookups_q + 32'd1;
            if (fetch_en && fetch_hit)
                hits_q <= hits_q + 32'd1;
            if (mis_cond)
                mispredicts_q <= mispredicts_q + 32'd1;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = mispredicts_q;
`else
    logic unused_fetch_en;
    assign unused_fetch_en  = fetch_en;
    assign stat_lookups     = '0;
    assign stat_hits        = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor: lookup, training, aliasing, same-cycle update, wrap and reset.
module tb_btb_predictor;
    logic        clk, rst, fetch_en;
    logic [31:0] fetch_pc, pred_target;
    logic        pred_taken;
    logic        upd_valid, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, stat_lookups, stat_hits, stat_mispredicts;

    int errors = 0;
    int checks = 0;

    btb_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .stat_lookups    (stat_lookups),
        .stat_hits       (stat_hits),
        .stat_mispredicts(stat_mispredicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                          input logic [31:0] exp_target);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, pred_target, exp_target);
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
        set_upd(pc, taken, tgt, ptaken, ptgt);
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic check_mis(input string tag, input logic exp_mis, input logic [31:0] exp_pc);
        check({tag, "_mis"}, {31'd0, mispredict}, {31'd0, exp_mis});
        check({tag, "_redir"}, redirect_pc, exp_pc);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; fetch_pc = 32'h10;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        #1 rst = 1'b0;
        #1;
        lookup("rst_lookup", 32'h10, 1'b0, 32'h11);
        check_mis("rst", 1'b0, 32'h0);
        check("rst_stat_lookups", stat_lookups, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Allocate 0x10 -> 0x40 with a not-taken prediction: mispredict pulse for one cycle.
        upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h11);
        check_mis("alloc", 1'b1, 32'h40);
        lookup("alloc_lookup", 32'h10, 1'b1, 32'h40);
        tick();
        check_mis("alloc_clear", 1'b0, 32'h40);

        // Three correct taken trainings saturate the counter at 2'b11.
        for (int i = 0; i < 3; i++) upd(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
        check_mis("train_ok", 1'b0, 32'h40);
        upd(32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
        check_mis("nt1", 1'b1, 32'h11);
        lookup("nt1_lookup", 32'h10, 1'b1, 32'h40);
        upd(32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
        check_mis("nt2_b2b", 1'b1, 32'h11);
        lookup("nt2_lookup", 32'h10, 1'b0, 32'h11);

        // Alias: 0x30 shares index 0x10 with a different tag.
        upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h11);
        lookup("realloc_lookup", 32'h10, 1'b1, 32'h40);
        upd(32'h30, 1'b1, 32'h80, 1'b0, 32'h31);
        check_mis("alias", 1'b1, 32'h80);
        lookup("alias_old", 32'h10, 1'b0, 32'h11);
        lookup("alias_new", 32'h30, 1'b1, 32'h80);

        // Same-cycle update and lookup of 0x20.
        fetch_pc = 32'h20;
        set_upd(32'h20, 1'b1, 32'h55, 1'b0, 32'h21);
        lookup("same_pre", 32'h20, 1'b0, 32'h21);
        tick();
        upd_valid = 1'b0;
        lookup("same_post", 32'h20, 1'b1, 32'h55);

        // Saturating decrement floor: 10 -> 01 -> 00 -> 00, then one taken -> 01.
        for (int i = 0; i < 3; i++) upd(32'h20, 1'b0, 32'h55, 1'b0, 32'h21);
        check_mis("dec_nomis", 1'b0, 32'h55);
        upd(32'h20, 1'b1, 32'h55, 1'b0, 32'h21);
        lookup("floor_lookup", 32'h20, 1'b0, 32'h21);
        upd(32'h20, 1'b1, 32'h66, 1'b0, 32'h21);
        lookup("floor_up", 32'h20, 1'b1, 32'h66);

        // Wrong target with correct direction still mispredicts.
        upd(32'h20, 1'b1, 32'h77, 1'b1, 32'h66);
        check_mis("tgt_mis", 1'b1, 32'h77);

        // PC+1 wraps at the top of the address space.
        upd(32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 32'h1234);
        check_mis("wrap", 1'b1, 32'h0);
        lookup("wrap_lookup", 32'hFFFF_FFFF, 1'b0, 32'h0);

        // Asynchronous reset mid-sequence while a mispredict is pending.
        upd(32'h30, 1'b0, 32'h80, 1'b1, 32'h80);
        check_mis("pre_rst", 1'b1, 32'h31);
        rst = 1'b0;
        #1;
        check_mis("mid_rst", 1'b0, 32'h0);
        lookup("mid_rst_30", 32'h30, 1'b0, 32'h31);
        lookup("mid_rst_20", 32'h20, 1'b0, 32'h21);
        tick();
        rst = 1'b1;
        tick();

        // Statistics: two mispredicting allocations, then 10 fetches with 4 hits.
        upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h11);
        upd(32'h11, 1'b1, 32'h41, 1'b0, 32'h12);
        tick();
        fetch_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fetch_pc = (i < 4) ? 32'h10 + 32'(i % 2) : 32'h100 + 32'(i);
            tick();
        end
        fetch_en = 1'b0;
        tick();
`ifdef BTB_STATS_EN
        check("stat_lookups", stat_lookups, 32'd10);
        check("stat_hits", stat_hits, 32'd4);
        check("stat_mispredicts", stat_mispredicts, 32'd2);
`else
        check("stat_lookups_off", stat_lookups, 32'd0);
        check("stat_hits_off", stat_hits, 32'd0);
        check("stat_mispredicts_off", stat_mispredicts, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters, one per entry.
- Sits directly upstream of the IF stage and drives the next-fetch PC.
- Looks up the current fetch PC combinationally and returns a predicted next PC.
- Is trained by the resolved branch outcome from the MEM stage.
- Also detects mispredictions and issues a registered redirect pulse for the PC mux and pipeline flush.

Parameters:
- XLEN, 32, PC and target width.
- IDX_W, 5, index width; ENTRIES = 2**IDX_W (32).
- CTR_INIT, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- fetch_en  input  1  IF stage is issuing fetch_pc this cycle; deasserted while PCwrite is stalled.
- fetch_pc  input  XLEN  word-addressed PC being fetched.
- pred_taken  output  1  predicted taken for fetch_pc.
- pred_target  output  XLEN  predicted next PC.
- upd_valid  input  1  resolved branch present in MEM.
- upd_pc  input  XLEN  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  XLEN  actual taken target (PC + offset).
- upd_pred_taken  input  1  prediction carried down the pipe with the branch.
- upd_pred_target  input  XLEN  predicted next PC carried with the branch.
- mispredict  output  1  registered one-cycle redirect/flush pulse.
- redirect_pc  output  XLEN  correct next PC, valid when mispredict=1.
- stat_lookups  output  32  statistics counter (see optional feature).
- stat_hits  output  32  statistics counter (see optional feature).
- stat_mispredicts  output  32  statistics counter (see optional feature).

Behaviour:
- PCs are word addresses; sequential next PC is pc+1.
- Index = pc[IDX_W-1:0]; tag = pc[XLEN-1:IDX_W].
- Entry fields: valid, tag, target[XLEN], ctr[2].
- Reset (rst=0, asynchronous):
  - all valid bits cleared; all ctr set to CTR_INIT.
  - mispredict=0, redirect_pc=0, stat counters=0.
  - tags and targets need no reset.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[idx] && tag matches.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : fetch_pc+1.
  - During reset pred_taken=0 and pred_target=fetch_pc+1.
- Update (rising edge with upd_valid=1, index/tag taken from upd_pc):
  - hit, upd_taken=1: ctr saturating increment (max 2'b11); target <= upd_target.
  - hit, upd_taken=0: ctr saturating decrement (min 2'b00); target unchanged.
  - miss, upd_taken=1: allocate and overwrite any alias: valid=1, tag, target=upd_target, ctr=2'b10.
  - miss, upd_taken=0: no change.
- Misprediction (registered, 1-cycle latency):
  - mispredict <= upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc <= upd_taken ? upd_target : upd_pc+1, loaded only when the mispredict condition is true; otherwise held.
  - mispredict is high for exactly one cycle per event; back-to-back events produce back-to-back pulses.
- Simultaneous lookup and update on the same index: lookup returns pre-update contents; new contents are visible the next cycle.
- upd_pc+1 and fetch_pc+1 wrap modulo 2**XLEN.
- fetch_en gates only the statistics counters; lookup is always active.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - stat_lookups increments on every cycle with fetch_en=1.
  - stat_hits increments when fetch_en=1 && hit.
  - stat_mispredicts increments on each cycle the mispredict register is loaded with 1.
  - All three wrap at 2**32 and clear on reset.
- Undefined: no counter logic is built and the three stat ports are tied to 0.

Test Plan:
- Reset then lookup fetch_pc=0x10 -> pred_taken=0, pred_target=0x11; mispredict=0.
- upd_valid, upd_pc=0x10, taken, target=0x40, pred_taken=0 -> next cycle mispredict=1 with redirect_pc=0x40, then 0 the following cycle; lookup 0x10 -> pred_taken=1, pred_target=0x40.
- Train 0x10 taken three times more, then not-taken once -> ctr=2'b10, still predicts taken; a second not-taken -> ctr=2'b01, predicts 0x11 and mispredict redirect_pc=0x11.
- Alias: allocate 0x10->0x40, then update 0x30 taken->0x80 (same index) -> lookup 0x10 misses (pred_target 0x11); lookup 0x30 hits, pred_target=0x80.
- Update and lookup 0x20 in the same cycle -> lookup shows the old entry, next cycle the new one; asserting rst mid-sequence -> all lookups miss immediately and mispredict=0.
- With BTB_STATS_EN defined: 10 fetch_en cycles, 4 of them hits, 2 mispredicts -> stat_lookups=10, stat_hits=4, stat_mispredicts=2.
